// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage behind the 8-bit ALU: ALU ops retire as a one-cycle
// register-file write, LD/ST run a req/ack memory handshake with a sticky timeout fault.
package mem_wb_pkg;

  typedef enum logic [4:0] {
    kADD = 5'd0,
    kSUB = 5'd1,
    kAND = 5'd2,
    kXOR = 5'd3,
    kSLL = 5'd4,
    kSRL = 5'd5,
    kMOV = 5'd6,
    kCMP = 5'd7,
    kBE  = 5'd8,
    kBL  = 5'd9,
    kBG  = 5'd10,
    kBA  = 5'd11,
    kLD  = 5'd12,
    kST  = 5'd13
  } op_e;

endpackage

module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    op,
  input  logic [AW-1:0] alu_rslt,
  input  logic [DW-1:0] st_data,
  input  logic [RW-1:0] dst_in,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          wb_en,
  output logic [RW-1:0] wb_dst,
  output logic [DW-1:0] wb_data,
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LastWait = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          wb_en_q;
  logic [RW-1:0] wb_dst_q;
  logic [DW-1:0] wb_data_q;
  logic          err_q;

  function automatic logic is_alu_wb(input logic [4:0] code);
    case (code)
      kADD, kSUB, kAND, kXOR, kSLL, kSRL, kMOV: is_alu_wb = 1'b1;
      default:                                  is_alu_wb = 1'b0;
    endcase
  endfunction

  // Handshake outputs are decoded from state alone, so no input reaches an output combinationally.
  assign in_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_en     = wb_en_q;
  assign wb_dst    = wb_dst_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_en_q     <= 1'b0;
      wb_dst_q    <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (is_alu_wb(op)) begin
              wb_en_q   <= 1'b1;
              wb_data_q <= DW'(alu_rslt);
              wb_dst_q  <= dst_in;
            end else if (op == kLD || op == kST) begin
              mem_addr_q <= alu_rslt;
              mem_we_q   <= (op == kST);
              if (op == kST) mem_wdata_q <= st_data;
              wb_dst_q   <= dst_in;
              cnt_q      <= '0;
              state_q    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack) begin
            if (!mem_we_q) wb_data_q <= mem_rdata;
            wb_en_q <= ~mem_we_q;
            state_q <= S_DONE;
          end else if (cnt_q == LastWait) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: scoreboarded write-backs, a programmable-latency memory
// responder, and timing checks on handshake, timeout and reset behaviour.
module tb_mem_wb_stage;
  import mem_wb_pkg::*;

  logic       clk, reset, in_valid, in_ready;
  logic [4:0] op;
  logic [7:0] alu_rslt, st_data, mem_rdata;
  logic [2:0] dst_in;
  logic       mem_req, mem_we, mem_ack, wb_en, err;
  logic [7:0] mem_addr, mem_wdata, wb_data;
  logic [2:0] wb_dst;

  int checks = 0;
  int errors = 0;

  logic [10:0] sb[$];
  int          ack_delay = -1;
  int          req_age = 0;
  int          mreq_cnt = 0;
  int          wb_count = 0;
  logic [7:0]  wb_hist = '0;
  logic [7:0]  exp_addr = '0, exp_wdata = '0;
  logic        exp_we = 1'b0;

  mem_wb_stage #(.AW(8), .DW(8), .RW(3), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .alu_rslt(alu_rslt), .st_data(st_data), .dst_in(dst_in), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Drives one instruction and holds it until the stage accepts it.
  task automatic issue(input logic [4:0] o, input logic [7:0] r, input logic [7:0] s,
                       input logic [2:0] d, output int waited);
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o; alu_rslt = r; st_data = s; dst_in = d;
    while (in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_bound", 32'(waited < 100), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Memory responder: acks ack_delay cycles into a request; ack_delay < 0 never acks.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        mem_ack = (ack_delay >= 0 && req_age == ack_delay);
        req_age++;
      end else begin
        mem_ack = 1'b0;
        req_age = 0;
      end
    end
  end

  // Monitor: request stability and scoreboarded write-backs.
  initial begin
    logic [10:0] exp_wb;
    forever begin
      @(negedge clk);
      wb_hist = {wb_hist[6:0], wb_en};
      if (mem_req === 1'b1) begin
        mreq_cnt++;
        check("req_addr", mem_addr, exp_addr);
        check("req_we", mem_we, exp_we);
        check("req_wdata", mem_wdata, exp_wdata);
      end
      if (wb_en === 1'b1) begin
        wb_count++;
        if (sb.size() == 0) check("wb_spurious", wb_en, 0);
        else begin
          exp_wb = sb.pop_front();
          check("wb_dst", wb_dst, exp_wb[10:8]);
          check("wb_data", wb_data, exp_wb[7:0]);
        end
      end
    end
  end

  initial begin
    int w;
    int wb_before;
    reset = 1'b1; in_valid = 1'b0; op = '0; alu_rslt = '0; st_data = '0; dst_in = '0;
    mem_rdata = '0;
    sample();
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_dst", wb_dst, 0);
    reset = 1'b0;

    // 1: ALU op writes back the following cycle.
    sb.push_back({3'd3, 8'h3C});
    issue(kADD, 8'h3C, 8'h00, 3'd3, w);
    sample();
    check("add_wb_en", wb_en, 1);
    check("add_wb_data", wb_data, 8'h3C);
    check("add_wb_dst", wb_dst, 3);
    check("add_no_req", mem_req, 0);

    // 2: zero-wait load.
    exp_addr = 8'h20; exp_we = 1'b0; ack_delay = 0; mem_rdata = 8'hA5; mreq_cnt = 0;
    sb.push_back({3'd2, 8'hA5});
    issue(kLD, 8'h20, 8'h00, 3'd2, w);
    sample();
    check("ld_req_c1", mem_req, 1);
    check("ld_ready_c1", in_ready, 0);
    check("ld_wb_c1", wb_en, 0);
    sample();
    check("ld_req_c2", mem_req, 0);
    check("ld_wb_c2", wb_en, 1);
    check("ld_data_c2", wb_data, 8'hA5);
    check("ld_ready_c2", in_ready, 0);
    sample();
    check("ld_ready_c3", in_ready, 1);
    check("ld_wb_c3", wb_en, 0);
    check("ld_req_cycles", mreq_cnt, 1);

    // 3: store with four wait cycles, next instruction held during the stall.
    exp_addr = 8'h41; exp_we = 1'b1; exp_wdata = 8'h7E; ack_delay = 4; mreq_cnt = 0;
    wb_before = wb_count;
    issue(kST, 8'h41, 8'h7E, 3'd5, w);
    sb.push_back({3'd2, 8'h99});
    issue(kXOR, 8'h99, 8'h00, 3'd2, w);
    check("st_stall_cycles", w, 6);
    check("st_req_cycles", mreq_cnt, 5);
    check("st_no_wb", wb_count, wb_before);
    sample();
    check("xor_wb_en", wb_en, 1);
    sample();
    check("xor_once", wb_count, wb_before + 1);

    // 4: load that never completes times out after TIMEOUT request cycles.
    exp_addr = 8'h33; exp_we = 1'b0; ack_delay = -1; mreq_cnt = 0;
    wb_before = wb_count;
    issue(kLD, 8'h33, 8'h00, 3'd4, w);
    w = 0;
    do begin
      sample();
      w++;
    end while (in_ready !== 1'b1 && w < 100);
    check("to_bound", 32'(w < 100), 1);
    check("to_req_cycles", mreq_cnt, 15);
    check("to_err", err, 1);
    check("to_no_wb", wb_count, wb_before);
    sb.push_back({3'd6, 8'h5A});
    issue(kXOR, 8'h5A, 8'h00, 3'd6, w);
    sample();
    check("to_xor_wb", wb_en, 1);
    check("to_err_sticky", err, 1);

    // 5: back-to-back SUB, CMP, MOV.
    sb.push_back({3'd1, 8'h11});
    issue(kSUB, 8'h11, 8'h00, 3'd1, w);
    issue(kCMP, 8'h22, 8'h00, 3'd4, w);
    sb.push_back({3'd7, 8'h33});
    issue(kMOV, 8'h33, 8'h00, 3'd7, w);
    sample();
    check("b2b_pattern", wb_hist[2:0], 3'b101);

    // 6: reset during the third wait cycle of a load.
    exp_addr = 8'h66; exp_we = 1'b0; ack_delay = -1;
    issue(kLD, 8'h66, 8'h00, 3'd1, w);
    sample();
    sample();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_err", err, 0);
    check("rst_mid_wb", wb_en, 0);
    wb_before = wb_count;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) sample();
    check("rst_after_no_wb", wb_count, wb_before);
    check("rst_after_ready", in_ready, 1);
    check("rst_after_err", err, 0);

    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access/write-back stage directly downstream of the 8-bit ALU.
- Takes each issued instruction's opcode, ALU result and store data.
- LD/ST: runs a variable-latency req/ack handshake with data memory, using the ALU result as the address.
- Register-writing ALU ops: produces a one-cycle registered write-back to the register file.
- Stalls upstream with in_ready while a memory access is outstanding.

Parameters:
- AW, 8: memory address width; equals ALU result width.
- DW, 8: data width.
- RW, 3: destination register index width.
- TIMEOUT, 15: max ACCESS cycles without mem_ack before fault; legal range 1..255.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream instruction valid this cycle.
- in_ready  output  1  stage can accept an instruction this cycle.
- op  input  5  opcode, encoded per the definitions package (kADD..kST).
- alu_rslt  input  AW  ALU result; the write-back value, or the LD/ST address.
- st_data  input  DW  store data from the register file; used only for kST.
- dst_in  input  RW  destination register index.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write (ST), 0 = read (LD).
- mem_addr  output  AW  request address.
- mem_wdata  output  DW  write data.
- mem_rdata  input  DW  read data; valid in the cycle mem_ack is high.
- mem_ack  input  1  memory completion.
- wb_en  output  1  register-file write enable; one-cycle pulse.
- wb_dst  output  RW  write-back register index.
- wb_data  output  DW  write-back value.
- err  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, immediate):
  - State IDLE; mem_req, mem_we, wb_en, err = 0.
  - mem_addr, mem_wdata, wb_dst, wb_data = 0; timeout counter = 0.
  - Reset during ACCESS drops mem_req at once; the pending LD produces no write-back.
- States: IDLE, ACCESS, DONE. All outputs are registered or decoded from state only; no combinational in->out paths.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid = 1:
    - kADD/kSUB/kAND/kXOR/kSLL/kSRL/kMOV: next cycle wb_en = 1, wb_data = alu_rslt, wb_dst = dst_in; remain IDLE. Back-to-back accepts give back-to-back wb pulses.
    - kLD/kST: latch mem_addr = alu_rslt, mem_we = (op == kST), mem_wdata = st_data (kST) or unchanged (kLD), wb_dst = dst_in; clear counter; go to ACCESS.
    - kCMP/kBE/kBL/kBG/kBA and unlisted codes: consumed, no write-back, no memory traffic.
- ACCESS:
  - in_ready = 0; mem_req = 1.
  - mem_addr, mem_we, mem_wdata held stable until completion.
  - mem_ack = 1 (legal in the first ACCESS cycle, i.e. zero-wait):
    - LD: wb_data = mem_rdata.
    - ST: wb_data unchanged.
    - Go to DONE; mem_req = 0 from the next cycle.
  - mem_ack = 0: counter increments. If the counter equals TIMEOUT-1 in a cycle without ack: set err = 1, return to IDLE, no write-back.
  - Ack and timeout in the same cycle: ack wins.
- DONE (one cycle):
  - wb_en = 1 for LD, 0 for ST; in_ready = 0.
  - Next state IDLE.
- Latency:
  - ALU-op write-back: 1 cycle after accept.
  - LD with ack in the first ACCESS cycle: accept at edge N, mem_req high in cycle N+1, wb_en high in cycle N+2, in_ready high again in cycle N+3.
- mem_ack while not in ACCESS: ignored.
- in_valid while in_ready = 0: ignored. Upstream must hold the instruction.
- err is sticky and cleared only by reset; the stage stays fully operational after a fault.
- Counter width: enough for TIMEOUT; no wrap before the compare.

Test Plan:
1. Reset, then kADD with alu_rslt = 8'h3C, dst_in = 3 -> next cycle wb_en = 1, wb_data = 8'h3C, wb_dst = 3; no mem_req.
2. kLD with alu_rslt = 8'h20, memory acks in the same cycle with rdata 8'hA5 -> mem_req high exactly 1 cycle at addr 8'h20, mem_we = 0; wb_en pulse with 8'hA5 two cycles after accept; in_ready low for 2 cycles.
3. kST with alu_rslt = 8'h41, st_data = 8'h7E, ack after 4 wait cycles -> mem_req held 5 cycles with addr/wdata stable and mem_we = 1; no wb_en; in_ready returns after DONE. A new in_valid held during the stall is accepted only once in_ready = 1.
4. kLD with mem_ack never asserted, TIMEOUT = 15 -> mem_req high 15 cycles then low; err = 1 and remains 1; no wb_en; a following kXOR still writes back normally.
5. Back-to-back kSUB, kCMP, kMOV -> wb pulses for kSUB and kMOV only, in consecutive-cycle order; the kCMP cycle has wb_en = 0.
6. Assert reset on the 3rd wait cycle of a kLD -> mem_req low immediately; no wb_en after reset release; err = 0; in_ready = 1.
